// File: rtl/kgp_pipelined_subtractor.sv
// 8-bit subtractor, 4-stage KGP recursive-doubling carry pipeline.
// Optional overflow output when KGP_SUB_OVF_EN is defined.
module kgp_pipelined_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] diff
`ifdef KGP_SUB_OVF_EN
  ,
  output logic       ovf
`endif
);

  // Each position is {x,y}: 00 kill, 11 generate, 01/10 propagate.
  typedef logic [8:0][1:0] kgp_t;

  function automatic logic [1:0] kgp_comb(
    input logic [1:0] past,
    input logic [1:0] pres
  );
    return (pres[1] ^ pres[0]) ? past : pres;
  endfunction

  function automatic kgp_t kgp_level(
    input kgp_t v,
    input int   d
  );
    kgp_t r;
    r = v;
    for (int i = d; i < 9; i++) begin
      r[i] = kgp_comb(v[i-d], v[i]);
    end
    return r;
  endfunction

  logic       advance;
  kgp_t       kgp_in;
  kgp_t       l1_d, l2_d, l4_d;
  kgp_t       s0_q, s1_q, s2_q;
  logic [7:0] s1_p_q, s2_p_q;
  logic       v0_q, v1_q, v2_q;
  logic       out_valid_q;
  logic [8:0] diff_q, diff_d;
  logic [1:0] cout_kgp;

  assign advance   = ~out_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;

  always_comb begin
    kgp_in    = '0;
    kgp_in[0] = {~bin, ~bin};
    for (int i = 0; i < 8; i++) begin
      kgp_in[i+1] = {a[i], ~b[i]};
    end
  end

  assign l1_d = kgp_level(s0_q, 1);
  assign l2_d = kgp_level(s1_q, 2);
  assign l4_d = kgp_level(s2_q, 4);

  // Position 8 spans 1..8 after distance 4; position 0 closes it.
  assign cout_kgp = kgp_comb(l4_d[0], l4_d[8]);

  always_comb begin
    diff_d = '0;
    for (int i = 0; i < 8; i++) begin
      diff_d[i] = s2_p_q[i] ^ l4_d[i][1];
    end
    diff_d[8] = ~cout_kgp[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
    end else if (advance) begin
      v0_q        <= in_valid;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      diff_q      <= diff_d;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s0_q <= kgp_in;
      s1_q <= l1_d;
      s2_q <= l2_d;
      for (int i = 0; i < 8; i++) begin
        s1_p_q[i] <= s0_q[i+1][1] ^ s0_q[i+1][0];
      end
      s2_p_q <= s1_p_q;
    end
  end

`ifdef KGP_SUB_OVF_EN
  logic s1_a7_q, s2_a7_q;
  logic ovf_q, ovf_d;

  // Operand signs differ exactly when bit 7 does not propagate.
  assign ovf_d = ~s2_p_q[7] & (diff_d[7] != s2_a7_q);
  assign ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_a7_q <= s0_q[8][1];
      s2_a7_q <= s1_a7_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_kgp_pipelined_subtractor.sv
// Self-checking bench for kgp_pipelined_subtractor.
// Reference model is plain integer arithmetic plus an in-order queue.
module tb_kgp_pipelined_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] diff;
`ifdef KGP_SUB_OVF_EN
  logic       ovf;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];
  logic       ovf_s;

  kgp_pipelined_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
`ifdef KGP_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ref_sub(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       c
  );
    int r;
    r = int'(x) - int'(y) - int'(c);
    return {(r < 0), 8'(r)};
  endfunction

  task automatic tick(
    input  logic       r,
    input  logic       v,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c,
    input  logic       ordy,
    output logic       acc,
    output logic       dlv,
    output logic       rdy,
    output logic       ov,
    output logic [8:0] d
  );
    rst_n     = r;
    in_valid  = v;
    a         = x;
    b         = y;
    bin       = c;
    out_ready = ordy;
    #1;
    rdy = in_ready;
    ov  = out_valid;
    d   = diff;
    acc = r & v & in_ready;
    dlv = r & out_valid & ordy;
    ovf_s = 1'b0;
`ifdef KGP_SUB_OVF_EN
    ovf_s = ovf;
`endif
    if (acc) exp_q.push_back(ref_sub(x, y, c));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic acc, dlv, rdy, ov;
    logic [8:0] d;
    tick(0, 0, 0, 0, 0, 0, acc, dlv, rdy, ov, d);
    tick(0, 0, 0, 0, 0, 0, acc, dlv, rdy, ov, d);
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got=%b want=1", rdy);
    end
    exp_q.delete();
    tick(1, 0, 0, 0, 0, 0, acc, dlv, rdy, ov, d);
    n_cmp++;
    if (ov !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid got=%b want=0", ov);
    end
    n_cmp++;
    if (d !== 9'h000) begin
      n_bad++;
      $display("FAIL reset_diff got=%h want=000", d);
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_in_ready got=%b want=1", rdy);
    end
  endtask

  task automatic test_basic();
    logic acc, dlv, rdy, ov;
    logic [8:0] d, e;
    int lat;
    lat = 0;
    tick(1, 1, 8'h50, 8'h20, 0, 1, acc, dlv, rdy, ov, d);
    n_cmp++;
    if (acc !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_accept got=%b want=1", acc);
    end
    for (int k = 1; k <= 7; k++) begin
      tick(1, 0, 0, 0, 0, 1, acc, dlv, rdy, ov, d);
      if (dlv) begin
        if (lat == 0) lat = k;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        n_cmp++;
        if (d !== 9'h030 || d !== e) begin
          n_bad++;
          $display("FAIL basic_diff got=%h want=030", d);
        end
      end
    end
    n_cmp++;
    if (lat != 4) begin
      n_bad++;
      $display("FAIL basic_latency got=%0d want=4", lat);
    end
  endtask

  task automatic test_borrow();
    logic acc, dlv, rdy, ov;
    logic [8:0] d, e;
    int got;
    got = 0;
    tick(1, 1, 8'h00, 8'h01, 0, 1, acc, dlv, rdy, ov, d);
    tick(1, 1, 8'hFF, 8'hFF, 1, 1, acc, dlv, rdy, ov, d);
    for (int k = 0; k < 8; k++) begin
      tick(1, 0, 0, 0, 0, 1, acc, dlv, rdy, ov, d);
      if (dlv) begin
        got++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        n_cmp++;
        if (d !== 9'h1FF || d !== e) begin
          n_bad++;
          $display("FAIL borrow_diff%0d got=%h want=1ff", got, d);
        end
      end
    end
    n_cmp++;
    if (got != 2) begin
      n_bad++;
      $display("FAIL borrow_count got=%0d want=2", got);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, dlv, rdy, ov;
    logic [8:0] d, e, frozen;
    logic [7:0] x, y;
    logic c;
    int sent, got, stall;
    bit seen;
    sent = 0;
    got = 0;
    stall = 0;
    seen = 0;
    frozen = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (out_valid && !seen) begin
        seen = 1;
        stall = 3;
        frozen = diff;
      end
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      tick(1, sent < 6, x, y, c, stall == 0, acc, dlv, rdy, ov, d);
      if (acc) sent++;
      if (stall > 0) begin
        stall--;
        n_cmp++;
        if (rdy !== 1'b0 || d !== frozen || ov !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_stall rdy=%b diff=%h want rdy=0 diff=%h", rdy, d, frozen);
        end
      end
      if (dlv) begin
        got++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        n_cmp++;
        if (d !== e) begin
          n_bad++;
          $display("FAIL b2b_diff%0d got=%h want=%h", got, d, e);
        end
      end
    end
    n_cmp++;
    if (got != 6) begin
      n_bad++;
      $display("FAIL b2b_count got=%0d want=6", got);
    end
  endtask

  task automatic test_reset_flush();
    logic acc, dlv, rdy, ov;
    logic [8:0] d;
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 8'($urandom), 8'($urandom), 0, 1, acc, dlv, rdy, ov, d);
    end
    tick(0, 0, 0, 0, 0, 1, acc, dlv, rdy, ov, d);
    exp_q.delete();
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_rdy_in_reset got=%b want=1", rdy);
    end
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, 0, 0, 0, 1, acc, dlv, rdy, ov, d);
      n_cmp++;
      if (ov !== 1'b0 || rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL flush_cycle%0d out_valid=%b in_ready=%b want 0/1", k, ov, rdy);
      end
    end
  endtask

`ifdef KGP_SUB_OVF_EN
  task automatic test_ovf();
    logic acc, dlv, rdy, ov;
    logic [8:0] d, e;
    logic [7:0] xs[2];
    logic [7:0] ys[2];
    logic       os[2];
    int got, r;
    xs[0] = 8'h80;
    ys[0] = 8'h01;
    xs[1] = 8'h10;
    ys[1] = 8'h05;
    for (int k = 0; k < 2; k++) begin
      r = int'($signed(xs[k])) - int'($signed(ys[k]));
      os[k] = (r < -128) || (r > 127);
    end
    got = 0;
    tick(1, 1, xs[0], ys[0], 0, 1, acc, dlv, rdy, ov, d);
    tick(1, 1, xs[1], ys[1], 0, 1, acc, dlv, rdy, ov, d);
    for (int k = 0; k < 8; k++) begin
      tick(1, 0, 0, 0, 0, 1, acc, dlv, rdy, ov, d);
      if (dlv && got < 2) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        n_cmp++;
        if (d !== e || ovf_s !== os[got]) begin
          n_bad++;
          $display("FAIL ovf_op%0d diff=%h ovf=%b want diff=%h ovf=%b", got, d, ovf_s, e, os[got]);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 2) begin
      n_bad++;
      $display("FAIL ovf_count got=%0d want=2", got);
    end
  endtask
`endif

  task automatic test_random();
    logic acc, dlv, rdy, ov, v, ordy, hold;
    logic [8:0] d, e, prev_d;
    int accepted, delivered;
    accepted = 0;
    delivered = 0;
    hold = 0;
    prev_d = '0;
    for (int cyc = 0; cyc < 60000 && delivered < 10000; cyc++) begin
      v    = (accepted < 10000) && ($urandom_range(0, 9) < 7);
      ordy = $urandom_range(0, 9) < 7;
      tick(1, v, 8'($urandom), 8'($urandom), 1'($urandom), ordy,
           acc, dlv, rdy, ov, d);
      if (hold) begin
        n_cmp++;
        if (ov !== 1'b1 || d !== prev_d) begin
          n_bad++;
          $display("FAIL rand_hold out_valid=%b diff=%h want 1/%h", ov, d, prev_d);
        end
      end
      hold = ov & ~ordy;
      prev_d = d;
      if (acc) accepted++;
      if (dlv) begin
        delivered++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        n_cmp++;
        if (d !== e) begin
          n_bad++;
          $display("FAIL rand_diff%0d got=%h want=%h", delivered, d, e);
        end
      end
    end
    n_cmp++;
    if (delivered != 10000 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rand_count got=%0d want=10000 left=%0d", delivered, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0;
    a = 0;
    b = 0;
    bin = 0;
    out_ready = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_reset_flush();
`ifdef KGP_SUB_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kgp_pipelined_subtractor.md
KGP_PIPELINED_SUBTRACTOR -- requirements
Module: kgp_pipelined_subtractor

Interface
REQ-001 SHALL have no parameters; operand width fixed at 8 bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port: in_valid  input  1  operands a, b, bin valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: a  input  8  minuend, unsigned.
REQ-007 SHALL have port: b  input  8  subtrahend, unsigned.
REQ-008 SHALL have port: bin  input  1  borrow-in.
REQ-009 SHALL have port: out_valid  output  1  diff holds a completed result.
REQ-010 SHALL have port: out_ready  input  1  downstream consumes diff this cycle.
REQ-011 SHALL have port: diff  output  9  diff[7:0] = (a - b - bin) mod 256; diff[8] = borrow-out, 1 iff a < b + bin.
REQ-012 SHALL have port (only with SUB_OVF_EN): ovf  output  1  signed two's-complement overflow.

Function
REQ-013 SHALL compute the difference as a + ~b + ~bin using KGP recursive doubling, where position 0 is the carry-in {~bin,~bin} and position i+1 is {a[i],~b[i]}.
REQ-014 SHALL apply the KGP combine rule (past, present): present K or G -> present; present P -> past.
REQ-015 SHALL use exactly four register stages: S0 captures the KGP vector; S1 combines at distance 1; S2 at distance 2; S3 at distance 4, then forms the sum bits and diff[8] = NOT(carry-out).
REQ-016 SHALL give a latency of 4 cycles: operands accepted on edge N produce out_valid=1 with the matching diff after edge N+3.
REQ-017 SHALL accept a transfer on an edge where in_valid & in_ready = 1, and deliver one on an edge where out_valid & out_ready = 1.
REQ-018 SHALL define advance = ~out_valid | out_ready; in_ready = advance; all stages and their valid bits shift only when advance = 1.
REQ-019 SHALL hold diff, out_valid and all stage contents stable while out_valid=1 and out_ready=0.
REQ-020 SHALL propagate bubbles: an unaccepted cycle enters S0 with valid=0; bubbles are not collapsed.
REQ-021 SHALL sustain 1 result/cycle with in_valid and out_ready continuously high.
REQ-022 SHALL never drop, duplicate or reorder results.
REQ-023 SHALL drive diff only from the S3 register, with no combinational path from a/b to diff.
REQ-024 SHALL make in_ready depend combinationally only on out_valid and out_ready.

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, clear every stage valid bit, out_valid, diff and ovf to 0.
REQ-026 SHALL, on reset asserted mid-operation, discard all in-flight results; out_valid=0 from the next cycle and no pre-reset result appears afterwards.
REQ-027 SHALL keep in_ready=1 during and immediately after reset, since out_valid=0.

Configuration
REQ-028 SHALL, with macro KGP_SUB_OVF_EN defined, add port ovf, pipelined alongside diff, with ovf = (a[7] != b[7]) & (diff[7] != a[7]).
REQ-029 SHALL, without KGP_SUB_OVF_EN, have no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-030 SHALL pass: a=0x50, b=0x20, bin=0, out_ready=1 -> out_valid after 4 cycles with diff=9'h030.
REQ-031 SHALL pass: a=0x00, b=0x01, bin=0 -> diff=9'h1FF; then a=0xFF, b=0xFF, bin=1 -> diff=9'h1FF.
REQ-032 SHALL pass: 6 back-to-back operations with out_ready held 0 for 3 cycles after the first result -> in_ready=0 and diff frozen for those cycles; all 6 results arrive in order.
REQ-033 SHALL pass: rst_n pulsed low for 1 cycle with 3 operations in flight -> out_valid=0 next cycle and for 4 cycles after, unless new operands are accepted.
REQ-034 SHALL pass, with KGP_SUB_OVF_EN: a=0x80, b=0x01, bin=0 -> diff=9'h07F, ovf=1; a=0x10, b=0x05 -> ovf=0.
REQ-035 SHALL pass: random in_valid and out_ready over 10000 operations -> every diff matches the reference model a - b - bin, with no loss or reordering.
